// File: rtl/nbody_pair_sched_if.sv
// Control/strobe bundle between the n-body register file, the pair scheduler and the datapath.
// master: scheduler side (drives status and strobes, receives commands and config).
// slave: register-file/datapath side (drives commands and config, receives status and strobes).
interface nbody_pair_sched_if #(
  parameter int BA     = 9,
  parameter int LANES  = 1,
  parameter int STEP_W = 16
);
  logic                  start;
  logic                  abort;
  logic                  ack;
  logic [BA:0]           num_bodies;
  logic [STEP_W-1:0]     num_steps;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [STEP_W-1:0]     step_cnt;
  logic                  iss_valid;
  logic [BA-1:0]         iss_i;
  logic [LANES*BA-1:0]   iss_j;
  logic [LANES-1:0]      iss_lane_en;
  logic                  ret_valid;
  logic [BA-1:0]         ret_i;
  logic [LANES-1:0]      ret_lane_en;
  logic                  ret_first;
  logic                  ret_last;
  logic                  vel_wr_en;
  logic [BA-1:0]         vel_wr_addr;
  logic [BA-1:0]         pos_rd_addr;
  logic                  pos_wr_en;
  logic [BA-1:0]         pos_wr_addr;

  modport master (
    input  start, abort, ack, num_bodies, num_steps,
    output busy, done, err, step_cnt,
    output iss_valid, iss_i, iss_j, iss_lane_en,
    output ret_valid, ret_i, ret_lane_en, ret_first, ret_last,
    output vel_wr_en, vel_wr_addr, pos_rd_addr, pos_wr_en, pos_wr_addr
  );

  modport slave (
    output start, abort, ack, num_bodies, num_steps,
    input  busy, done, err, step_cnt,
    input  iss_valid, iss_i, iss_j, iss_lane_en,
    input  ret_valid, ret_i, ret_lane_en, ret_first, ret_last,
    input  vel_wr_en, vel_wr_addr, pos_rd_addr, pos_wr_en, pos_wr_addr
  );
endinterface

// File: rtl/nbody_pair_sched.sv
// Pairwise (i,j) issue sequencer for the n-body accelerator: accel loop, drains, position update, step repeat.
// Latency: first issue 2 cycles after start; ret = issue + RAM_LAT+PIPE_LAT; vel = ret + ACC_LAT; pos_wr = pos_rd + RAM_LAT+ACC_LAT.
// No backpressure: datapath accepts one strobe per cycle; abort flushes every in-flight tag immediately.
module nbody_pair_sched #(
  parameter int BODIES   = 512,
  parameter int LANES    = 1,
  parameter int RAM_LAT  = 1,
  parameter int PIPE_LAT = 118,
  parameter int ACC_LAT  = 20,
  parameter int STEP_W   = 16
) (
  input logic                clk,
  input logic                rst,
  nbody_pair_sched_if.master bus
);
  localparam int BA        = $clog2(BODIES);
  localparam int RET_LAT   = RAM_LAT + PIPE_LAT;
  localparam int POS_LAT   = RAM_LAT + ACC_LAT;
  localparam int DRAIN_CYC = RET_LAT + ACC_LAT;
  localparam int WW        = $clog2(DRAIN_CYC + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEL, S_DRAIN, S_POSUPD, S_PDRAIN, S_DONE
  } state_t;

  // Tag carried alongside an issued pair through the RAM + getAccl latency.
  typedef struct packed {
    logic             vld;
    logic [BA-1:0]    i;
    logic [LANES-1:0] lane_en;
    logic             first;
    logic             last;
  } tag_t;

  // Write strobe with its address, used for both velocity and position delay lines.
  typedef struct packed {
    logic          vld;
    logic [BA-1:0] addr;
  } wr_t;

  state_t              state, state_nxt;
  logic [BA:0]         nb_q;
  logic [STEP_W-1:0]   ns_q;
  logic [STEP_W-1:0]   step_q;
  logic                err_q;
  logic [BA-1:0]       i_q;
  logic [BA-1:0]       jb_q;
  logic [BA-1:0]       p_q;
  logic [WW-1:0]       w_q;
  tag_t                iss_q;
  logic [LANES*BA-1:0] iss_j_q;
  logic [BA-1:0]       pos_rd_q;
  logic                pos_rd_vld;

  tag_t ret_pipe [RET_LAT];
  wr_t  vel_pipe [ACC_LAT];
  wr_t  pos_pipe [POS_LAT];
  tag_t ret_out;

  logic                cfg_bad;
  logic                jb_last;
  logic                i_last;
  logic                p_last;
  logic                drain_end;
  logic                pdrain_end;
  logic                step_last;
  logic [31:0]         jk;
  logic [LANES*BA-1:0] lane_j;
  logic [LANES-1:0]    lane_en;

  // Loop-end and configuration decodes, all compared at 32 bits so jb+LANES cannot wrap.
  always_comb begin
    cfg_bad    = (32'(bus.num_bodies) < 32'd2) || (32'(bus.num_bodies) > 32'(BODIES)) ||
                 (bus.num_steps == '0);
    jb_last    = (32'(jb_q) + 32'(LANES)) >= 32'(nb_q);
    i_last     = 32'(i_q) == (32'(nb_q) - 32'd1);
    p_last     = 32'(p_q) == (32'(nb_q) - 32'd1);
    drain_end  = 32'(w_q) == 32'(DRAIN_CYC - 1);
    pdrain_end = 32'(w_q) == 32'(POS_LAT - 1);
    step_last  = (32'(step_q) + 32'd1) == 32'(ns_q);
  end

  // Per-lane j index and validity: lane is live only inside the body range and off the diagonal.
  always_comb begin
    jk      = '0;
    lane_j  = '0;
    lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      jk                = 32'(jb_q) + 32'(k);
      lane_j[k*BA +: BA] = jk[BA-1:0];
      lane_en[k]        = (jk < 32'(nb_q)) && (jk != 32'(i_q));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (bus.start) state_nxt = cfg_bad ? S_DONE : S_ACCEL;
        S_ACCEL:  if (jb_last && i_last) state_nxt = S_DRAIN;
        S_DRAIN:  if (drain_end) state_nxt = S_POSUPD;
        S_POSUPD: if (p_last) state_nxt = S_PDRAIN;
        S_PDRAIN: if (pdrain_end) state_nxt = step_last ? S_DONE : S_ACCEL;
        S_DONE:   if (bus.ack) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, config latch and the registered issue / position-read strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nb_q       <= '0;
      ns_q       <= '0;
      step_q     <= '0;
      err_q      <= 1'b0;
      i_q        <= '0;
      jb_q       <= '0;
      p_q        <= '0;
      w_q        <= '0;
      iss_q      <= '0;
      iss_j_q    <= '0;
      pos_rd_q   <= '0;
      pos_rd_vld <= 1'b0;
    end else if (bus.abort) begin
      nb_q       <= '0;
      ns_q       <= '0;
      step_q     <= '0;
      err_q      <= 1'b0;
      i_q        <= '0;
      jb_q       <= '0;
      p_q        <= '0;
      w_q        <= '0;
      iss_q      <= '0;
      iss_j_q    <= '0;
      pos_rd_q   <= '0;
      pos_rd_vld <= 1'b0;
    end else begin
      iss_q      <= '0;
      iss_j_q    <= '0;
      pos_rd_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            nb_q   <= bus.num_bodies;
            ns_q   <= bus.num_steps;
            step_q <= '0;
            err_q  <= cfg_bad;
            i_q    <= '0;
            jb_q   <= '0;
            p_q    <= '0;
            w_q    <= '0;
          end
        end
        S_ACCEL: begin
          iss_q.vld     <= 1'b1;
          iss_q.i       <= i_q;
          iss_q.lane_en <= lane_en;
          iss_q.first   <= (jb_q == '0);
          iss_q.last    <= jb_last;
          iss_j_q       <= lane_j;
          if (jb_last) begin
            jb_q <= '0;
            i_q  <= i_last ? '0 : i_q + 1'b1;
          end else begin
            jb_q <= jb_q + BA'(LANES);
          end
        end
        S_DRAIN: begin
          w_q <= drain_end ? '0 : w_q + 1'b1;
        end
        S_POSUPD: begin
          pos_rd_vld <= 1'b1;
          pos_rd_q   <= p_q;
          p_q        <= p_last ? '0 : p_q + 1'b1;
        end
        S_PDRAIN: begin
          w_q <= pdrain_end ? '0 : w_q + 1'b1;
          if (pdrain_end) begin
            step_q <= step_q + 1'b1;
            i_q    <= '0;
            jb_q   <= '0;
            p_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ret_out = ret_pipe[RET_LAT-1];

  // Tag delay lines tracking the RAM/getAccl, AddSub and position-update pipelines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RET_LAT; k++) ret_pipe[k] <= '0;
      for (int k = 0; k < ACC_LAT; k++) vel_pipe[k] <= '0;
      for (int k = 0; k < POS_LAT; k++) pos_pipe[k] <= '0;
    end else if (bus.abort) begin
      for (int k = 0; k < RET_LAT; k++) ret_pipe[k] <= '0;
      for (int k = 0; k < ACC_LAT; k++) vel_pipe[k] <= '0;
      for (int k = 0; k < POS_LAT; k++) pos_pipe[k] <= '0;
    end else begin
      ret_pipe[0] <= iss_q;
      for (int k = 1; k < RET_LAT; k++) ret_pipe[k] <= ret_pipe[k-1];
      vel_pipe[0].vld  <= ret_out.vld & ret_out.last;
      vel_pipe[0].addr <= ret_out.i;
      for (int k = 1; k < ACC_LAT; k++) vel_pipe[k] <= vel_pipe[k-1];
      pos_pipe[0].vld  <= pos_rd_vld;
      pos_pipe[0].addr <= pos_rd_q;
      for (int k = 1; k < POS_LAT; k++) pos_pipe[k] <= pos_pipe[k-1];
    end
  end

  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.err         = err_q;
  assign bus.step_cnt    = step_q;
  assign bus.iss_valid   = iss_q.vld;
  assign bus.iss_i       = iss_q.i;
  assign bus.iss_j       = iss_j_q;
  assign bus.iss_lane_en = iss_q.lane_en;
  assign bus.ret_valid   = ret_out.vld;
  assign bus.ret_i       = ret_out.i;
  assign bus.ret_lane_en = ret_out.lane_en;
  assign bus.ret_first   = ret_out.first;
  assign bus.ret_last    = ret_out.last;
  assign bus.vel_wr_en   = vel_pipe[ACC_LAT-1].vld;
  assign bus.vel_wr_addr = vel_pipe[ACC_LAT-1].addr;
  assign bus.pos_rd_addr = pos_rd_q;
  assign bus.pos_wr_en   = pos_pipe[POS_LAT-1].vld;
  assign bus.pos_wr_addr = pos_pipe[POS_LAT-1].addr;
endmodule

// File: tb/tb_nbody_pair_sched.sv
// Directed bench for nbody_pair_sched with BODIES=8 LANES=2 RAM_LAT=1 PIPE_LAT=4 ACC_LAT=2.
// A negedge monitor logs every strobe with a cycle stamp; tests compare the logs to hand tables.
module tb_nbody_pair_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  nbody_pair_sched_if #(.BA(3), .LANES(2), .STEP_W(16)) bus ();

  nbody_pair_sched #(
    .BODIES(8), .LANES(2), .RAM_LAT(1), .PIPE_LAT(4), .ACC_LAT(2), .STEP_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          cyc = 0;
  logic [15:0] iss_rec [$];
  int          iss_cyc [$];
  logic [7:0]  ret_rec [$];
  int          ret_cyc [$];
  logic [2:0]  vel_rec [$];
  int          vel_cyc [$];
  logic [2:0]  pos_rec [$];
  int          pos_cyc [$];
  logic [15:0] step_rec [$];
  logic [15:0] step_prev = '0;
  logic        done_prev = 1'b0;
  int          done_rises = 0;

  // Strobe logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.iss_valid) begin
      iss_rec.push_back({5'd0, bus.iss_i, bus.iss_j[2:0], bus.iss_j[5:3], bus.iss_lane_en});
      iss_cyc.push_back(cyc);
    end
    if (bus.ret_valid) begin
      ret_rec.push_back({1'b0, bus.ret_i, bus.ret_lane_en, bus.ret_first, bus.ret_last});
      ret_cyc.push_back(cyc);
    end
    if (bus.vel_wr_en) begin
      vel_rec.push_back(bus.vel_wr_addr);
      vel_cyc.push_back(cyc);
    end
    if (bus.pos_wr_en) begin
      pos_rec.push_back(bus.pos_wr_addr);
      pos_cyc.push_back(cyc);
    end
    if (bus.step_cnt != step_prev) step_rec.push_back(bus.step_cnt);
    step_prev = bus.step_cnt;
    if (bus.done && !done_prev) done_rises++;
    done_prev = bus.done;
    cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int strobe_total();
    return iss_rec.size() + ret_rec.size() + vel_rec.size() + pos_rec.size();
  endfunction

  task automatic start_run(input int nb, input int ns);
    bus.num_bodies = 4'(nb);
    bus.num_steps  = 16'(ns);
    bus.start      = 1'b1;
    tick(1);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, int'(bus.done), 1);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
  endtask

  // nb=3 steps=1 reference run, checked against the hand-worked pair table.
  task automatic run_t1(input string p);
    int e_i  [6] = '{0, 0, 1, 1, 2, 2};
    int e_j0 [6] = '{0, 2, 0, 2, 0, 2};
    int e_j1 [6] = '{1, 3, 1, 3, 1, 3};
    int e_en [6] = '{2, 1, 1, 1, 3, 0};
    int e_f  [6] = '{1, 0, 1, 0, 1, 0};
    int e_l  [6] = '{0, 1, 0, 1, 0, 1};
    int bi = iss_rec.size();
    int br = ret_rec.size();
    int bv = vel_rec.size();
    int bp = pos_rec.size();
    logic [15:0] r;
    logic [7:0]  t;
    start_run(3, 1);
    wait_done({p, "_done"}, 300);
    tick(2);
    check({p, "_iss_n"}, iss_rec.size() - bi, 6);
    check({p, "_ret_n"}, ret_rec.size() - br, 6);
    if (iss_rec.size() >= bi + 6 && ret_rec.size() >= br + 6) begin
      for (int k = 0; k < 6; k++) begin
        r = iss_rec[bi+k];
        t = ret_rec[br+k];
        check({p, "_iss_i"},  int'(r[10:8]), e_i[k]);
        check({p, "_iss_j0"}, int'(r[7:5]),  e_j0[k]);
        check({p, "_iss_en"}, int'(r[1:0]),  e_en[k]);
        if ((e_en[k] & 2) != 0) check({p, "_iss_j1"}, int'(r[4:2]), e_j1[k]);
        check({p, "_iss_seq"}, iss_cyc[bi+k] - iss_cyc[bi], k);
        check({p, "_ret_i"},     int'(t[6:4]), e_i[k]);
        check({p, "_ret_en"},    int'(t[3:2]), e_en[k]);
        check({p, "_ret_first"}, int'(t[1]),   e_f[k]);
        check({p, "_ret_last"},  int'(t[0]),   e_l[k]);
        check({p, "_ret_lat"},   ret_cyc[br+k] - iss_cyc[bi+k], 5);
      end
    end
    check({p, "_vel_n"}, vel_rec.size() - bv, 3);
    check({p, "_pos_n"}, pos_rec.size() - bp, 3);
    if (vel_rec.size() >= bv + 3 && pos_rec.size() >= bp + 3 && ret_rec.size() >= br + 6) begin
      for (int k = 0; k < 3; k++) begin
        check({p, "_vel_addr"}, int'(vel_rec[bv+k]), k);
        check({p, "_vel_lat"},  vel_cyc[bv+k] - ret_cyc[br+2*k+1], 2);
        check({p, "_pos_addr"}, int'(pos_rec[bp+k]), k);
        check({p, "_pos_seq"},  pos_cyc[bp+k] - pos_cyc[bp], k);
      end
      check({p, "_pos_after_vel"}, int'(pos_cyc[bp] > vel_cyc[bv+2]), 1);
    end
    check({p, "_step"}, int'(bus.step_cnt), 1);
    check({p, "_err"},  int'(bus.err), 0);
    check({p, "_busy"}, int'(bus.busy), 0);
    do_ack();
    check({p, "_ack_done"}, int'(bus.done), 0);
  endtask

  initial begin
    int bad_nb [3] = '{1, 9, 3};
    int bad_ns [3] = '{1, 1, 0};
    int b0, bi, bv, bp, bs, dr, n;

    bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0;
    bus.num_bodies = '0; bus.num_steps = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err), 0);
    check("rst_step", int'(bus.step_cnt), 0);
    check("rst_strobes", int'({bus.iss_valid, bus.ret_valid, bus.vel_wr_en, bus.pos_wr_en}), 0);

    run_t1("t1");

    // Bad configurations: nb below 2, nb above BODIES, zero steps.
    for (int c = 0; c < 3; c++) begin
      b0 = strobe_total();
      start_run(bad_nb[c], bad_ns[c]);
      tick(1);
      check("t2_done", int'(bus.done), 1);
      check("t2_err",  int'(bus.err), 1);
      tick(5);
      check("t2_no_strobe", strobe_total() - b0, 0);
      check("t2_busy", int'(bus.busy), 0);
      do_ack();
      check("t2_ack", int'(bus.done), 0);
    end

    // Three steps of nb=4.
    bs = step_rec.size(); dr = done_rises;
    bi = iss_rec.size(); bv = vel_rec.size(); bp = pos_rec.size();
    start_run(4, 3);
    wait_done("t3_done", 600);
    tick(3);
    check("t3_done_once", done_rises - dr, 1);
    check("t3_step_n", step_rec.size() - bs, 3);
    if (step_rec.size() >= bs + 3)
      for (int k = 0; k < 3; k++) check("t3_step_seq", int'(step_rec[bs+k]), k + 1);
    check("t3_iss_n", iss_rec.size() - bi, 24);
    check("t3_vel_n", vel_rec.size() - bv, 12);
    check("t3_pos_n", pos_rec.size() - bp, 12);
    check("t3_step", int'(bus.step_cnt), 3);
    check("t3_err",  int'(bus.err), 0);
    do_ack();

    // Abort on the fifth issue of an nb=8 run.
    start_run(8, 2);
    n = 0;
    for (int k = 0; k < 50 && n < 5; k++) begin
      tick(1);
      if (bus.iss_valid) n++;
    end
    check("t4_reach5", n, 5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("t4_busy", int'(bus.busy), 0);
    check("t4_iss",  int'(bus.iss_valid), 0);
    b0 = strobe_total();
    tick(40);
    check("t4_quiet", strobe_total() - b0, 0);
    check("t4_done",  int'(bus.done), 0);

    // DONE ignores start; ack+start together returns to IDLE without a new run.
    bi = iss_rec.size();
    start_run(2, 1);
    wait_done("t5_done", 200);
    tick(2);
    check("t5_iss_n", iss_rec.size() - bi, 2);
    if (iss_rec.size() >= bi + 2) begin
      check("t5_i0",  int'(iss_rec[bi][10:8]), 0);
      check("t5_en0", int'(iss_rec[bi][1:0]), 2);
      check("t5_i1",  int'(iss_rec[bi+1][10:8]), 1);
      check("t5_en1", int'(iss_rec[bi+1][1:0]), 1);
    end
    for (int k = 0; k < 3; k++) begin
      start_run(3, 1);
      tick(1);
    end
    check("t5_hold_done", int'(bus.done), 1);
    check("t5_hold_step", int'(bus.step_cnt), 1);
    check("t5_hold_iss",  iss_rec.size() - bi, 2);
    bus.ack = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.ack = 1'b0; bus.start = 1'b0;
    check("t5_ack_done", int'(bus.done), 0);
    tick(20);
    check("t5_no_run",  iss_rec.size() - bi, 2);
    check("t5_busy",    int'(bus.busy), 0);
    check("t5_done_lo", int'(bus.done), 0);

    // Reset during the position update, then an exact rerun of the reference case.
    start_run(3, 1);
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      tick(1);
      if (bus.vel_wr_en) n++;
    end
    check("t6_vel3", n, 3);
    tick(2);
    check("t6_busy_pre", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_step", int'(bus.step_cnt), 0);
    check("t6_rst_addr", int'(bus.pos_rd_addr), 0);
    check("t6_rst_strobes",
          int'({bus.iss_valid, bus.ret_valid, bus.vel_wr_en, bus.pos_wr_en, bus.done, bus.err}), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    run_t1("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
